// File: rtl/stopwatch_pkg.sv
// Shared state encoding and transition helper for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_ADJUST = 2'd3
    } state_t;

    // Where a pause/resume press takes the FSM; ADJUST ignores it.
    function automatic state_t pause_next(input state_t s);
        case (s)
            ST_IDLE:  return ST_RUN;
            ST_RUN:   return ST_PAUSE;
            ST_PAUSE: return ST_RUN;
            default:  return s;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability counter and one-cycle press pulse for a raw button.
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The counter saturates at DB_CYCLES so a held button fires exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (!sync2) begin
                cnt <= '0;
            end else if (cnt != CW'(DB_CYCLES)) begin
                cnt <= cnt + 1'b1;
            end
            press <= sync2 && (cnt == CW'(DB_CYCLES - 1));
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced buttons, 1 Hz count divider, 2 Hz adjust/blink divider.
// Optional lap/display-hold feature enabled by defining STOPWATCH_CTRL_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIV_1HZ   = 100000000,
    parameter int DIV_2HZ   = 50000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pause,
    input  logic       btn_clr,
`ifdef STOPWATCH_CTRL_LAP_EN
    input  logic       btn_lap,
`endif
    input  logic [1:0] sw,
    output logic       cnt_en,
    output logic       adj_en,
    output logic       adj_sel,
    output logic       cnt_clr,
    output logic       blink,
    output logic [1:0] state
`ifdef STOPWATCH_CTRL_LAP_EN
    ,
    output logic       disp_hold
`endif
);

    localparam int W1 = $clog2(DIV_1HZ) + 1;
    localparam int W2 = $clog2(DIV_2HZ) + 1;

    logic          pause_ev;
    logic          clr_ev;
    logic [1:0]    sw_s1;
    logic [1:0]    sw_s2;
    state_t        st;
    logic [W1-1:0] div1;
    logic [W2-1:0] div2;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_pause),
        .press (pause_ev)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_clr),
        .press (clr_ev)
    );

    logic adj_req;
    logic adj_entry;
    logic adj_exit;
    logic stay_run;
    logic stay_adj;

    // ADJUST entry outranks every press; clear outranks pause.
    assign adj_req   = sw_s2[0];
    assign adj_entry = adj_req && (st != ST_ADJUST);
    assign adj_exit  = !adj_req && (st == ST_ADJUST);
    assign stay_run  = (st == ST_RUN) && !adj_entry && !clr_ev && !pause_ev;
    assign stay_adj  = (st == ST_ADJUST) && adj_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= ST_IDLE;
            sw_s1   <= '0;
            sw_s2   <= '0;
            div1    <= '0;
            div2    <= '0;
            cnt_en  <= 1'b0;
            adj_en  <= 1'b0;
            cnt_clr <= 1'b0;
            blink   <= 1'b0;
            adj_sel <= 1'b0;
        end else begin
            sw_s1   <= sw;
            sw_s2   <= sw_s1;
            adj_sel <= sw_s2[1];
            cnt_en  <= 1'b0;
            adj_en  <= 1'b0;
            cnt_clr <= clr_ev && !adj_entry;

            if (adj_entry) begin
                st    <= ST_ADJUST;
                div1  <= '0;
                div2  <= '0;
                blink <= 1'b0;
            end else if (adj_exit) begin
                st    <= ST_PAUSE;
                div2  <= '0;
                blink <= 1'b0;
                if (clr_ev) begin
                    div1 <= '0;
                end
            end else if (clr_ev) begin
                div1 <= '0;
                if (st == ST_RUN) begin
                    st <= ST_IDLE;
                end
            end else if (pause_ev) begin
                st <= pause_next(st);
            end

            // Counting is suppressed on the cycle RUN is left, so cnt_en stays inside RUN.
            if (stay_run) begin
                if (div1 == W1'(DIV_1HZ - 1)) begin
                    div1   <= '0;
                    cnt_en <= 1'b1;
                end else begin
                    div1 <= div1 + 1'b1;
                end
            end

            if (stay_adj) begin
                if (div2 == W2'(DIV_2HZ - 1)) begin
                    div2   <= '0;
                    adj_en <= 1'b1;
                    blink  <= ~blink;
                end else begin
                    div2 <= div2 + 1'b1;
                end
            end
        end
    end

    assign state = st;

`ifdef STOPWATCH_CTRL_LAP_EN
    logic lap_ev;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_lap),
        .press (lap_ev)
    );

    // Hold drops whenever the FSM is not staying in RUN, which covers clear and exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_hold <= 1'b0;
        end else if (!stay_run) begin
            disp_hold <= 1'b0;
        end else if (lap_ev) begin
            disp_hold <= ~disp_hold;
        end
    end
`endif

endmodule
